apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB slave register file that sits directly downstream of `apb_master` and terminates its transfers. It consumes the master's PSEL/PENABLE/PWRITE/PADDR/PWDATA and returns PRDATA/PREADY/PSLVERR. It holds NUM_REGS registers of DATA_WIDTH bits and inserts a fixed, parameterised number of wait states. Bus-side verification of the master uses it as the standard slave model; SoC integration uses it as real register storage.

## Interface
- ADDR_WIDTH, 8, address bus width; register index = PADDR_i.
- DATA_WIDTH, 8, data bus and register width.
- NUM_REGS, 32, number of registers; valid indices 0..NUM_REGS-1.
- WAIT_CYCLES, 0, wait states per transfer; range 0..15.

Ports:
- PCLK_i  in  1  clock; all logic on the rising edge.
- PRESET_i  in  1  reset, synchronous, active-low.
- PSEL_i  in  1  slave select from master.
- PENABLE_i  in  1  access-phase indicator.
- PWRITE_i  in  1  1 = write, 0 = read.
- PADDR_i  in  ADDR_WIDTH  register index.
- PWDATA_i  in  DATA_WIDTH  write data.
- PRDATA_o  out  DATA_WIDTH  read data; valid when PREADY_o=1 on a read.
- PREADY_o  out  1  transfer completion.
- PSLVERR_o  out  1  error response; meaningful only when PREADY_o=1.

## Operation
- FSM states: IDLE and ACCESS, plus a 4-bit wait counter `cnt`.
- IDLE:
  - At an edge sampling PSEL_i=1 and PENABLE_i=0 (setup phase): latch PADDR_i, PWRITE_i and PWDATA_i.
  - Set `cnt`=WAIT_CYCLES.
  - Compute `err` = (PADDR_i >= NUM_REGS).
  - If this is a read, load PRDATA_o with regs[PADDR_i], or 0 if `err`.
  - Go to ACCESS.
- ACCESS:
  - PREADY_o = (state==ACCESS && cnt==0). This is a Moore output, decoded from registers only.
  - `cnt` decrements each edge while nonzero and PSEL_i=1.
  - At an edge sampling PSEL_i=1, PENABLE_i=1 and PREADY_o=1, the transfer completes:
    - On a write without `err`, regs[latched addr] <= latched data.
    - Go to IDLE.
  - PSEL_i=0 sampled in ACCESS is a protocol abort: go to IDLE, no register update, PREADY_o falls next cycle.
- Address decode and data use the values latched in the setup phase. Changes on the master's buses during ACCESS are ignored.
- Erroring write: no register modified.
- Erroring read: PRDATA_o=0.
- PSLVERR_o = PREADY_o & `err` when APB_SLV_ERR_EN is defined, else 0.
- PRDATA_o holds its last value outside read transfers. Writes do not disturb it.

## Timing
- Reset (PRESET_i=0 at an edge):
  - All regs, PRDATA_o, PREADY_o, PSLVERR_o and `cnt` go to 0; state goes to IDLE.
  - Reset takes priority over any transfer in progress. An in-flight write is dropped.
- WAIT_CYCLES=0: PREADY_o is high in the first access cycle, so each transfer takes 2 PCLK cycles (setup + access). This is the zero-wait-state case the master expects.
- WAIT_CYCLES=N: PREADY_o is low for N access cycles and high in access cycle N+1, so each transfer takes N+2 cycles.
- Write data is visible to a read whose setup phase is sampled at least one edge after the completion edge.
- Back-to-back transfers:
  - The completion edge returns the FSM to IDLE.
  - The master's next setup phase is sampled at the following edge with no bubble.
  - IDLE must accept a setup phase on any cycle.
- PENABLE_i=1 sampled in IDLE (no preceding setup) is ignored; the FSM stays in IDLE.
- PSLVERR_o is never high while PREADY_o is low.

## Configuration
- APB_SLV_ERR_EN defined:
  - An out-of-range PADDR_i drives PSLVERR_o=1 together with PREADY_o.
  - The write is suppressed; a read returns 0.
- Not defined:
  - PSLVERR_o is tied to 0.
  - Out-of-range writes are silently dropped and reads return 0.
  - Timing is identical in both builds.

## Test plan
- Reset: hold PRESET_i=0 for 3 cycles, release, then read 0x03 -> PREADY_o=1 in the first access cycle, PRDATA_o=0x00, PSLVERR_o=0.
- WAIT_CYCLES=0: write 0x28 to 0x15, then read 0x15 -> each transfer takes 2 cycles, PREADY_o is high in the access cycle, read returns 0x28, PSLVERR_o=0.
- Back-to-back: write 0x72@0x01, 0x66@0x02, 0x09@0x03 with no idle cycles, then read all three -> returns 0x72, 0x66, 0x09; no transfer is lost or stretched.
- WAIT_CYCLES=2: write 0x87@0x04 -> PREADY_o low for 2 access cycles and high on the 3rd. Change PWDATA_i to 0x44 during the wait; a later read of 0x04 still returns 0x87.
- Error, macro defined: write 0x54 to 0x40 -> PSLVERR_o=1 with PREADY_o. A read of 0x40 returns 0x00 with PSLVERR_o=1. No register changes. Without the macro: same data behaviour, PSLVERR_o=0.
- Reset mid-transfer, WAIT_CYCLES=2: start write 0x99@0x05, drive PRESET_i=0 in the first wait cycle -> PREADY_o=0 next cycle, FSM in IDLE. After release, read 0x05 returns 0x00.

Source files
------------

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between apb_master and apb_slave_regfile.
// The master modport drives the request side; the slave modport returns the response.
interface apb_slave_regfile_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  PSEL_i;
    logic                  PENABLE_i;
    logic                  PWRITE_i;
    logic [ADDR_WIDTH-1:0] PADDR_i;
    logic [DATA_WIDTH-1:0] PWDATA_i;
    logic [DATA_WIDTH-1:0] PRDATA_o;
    logic                  PREADY_o;
    logic                  PSLVERR_o;

    modport master (
        output PSEL_i, PENABLE_i, PWRITE_i, PADDR_i, PWDATA_i,
        input  PRDATA_o, PREADY_o, PSLVERR_o
    );

    modport slave (
        input  PSEL_i, PENABLE_i, PWRITE_i, PADDR_i, PWDATA_i,
        output PRDATA_o, PREADY_o, PSLVERR_o
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB register file slave with a fixed number of wait states per transfer.
// Define APB_SLV_ERR_EN to report out-of-range addresses on PSLVERR_o.
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGS    = 32,
    parameter int WAIT_CYCLES = 0
) (
    input logic PCLK_i,
    input logic PRESET_i,
    apb_slave_regfile_if.slave bus
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                               state_q, state_d;
    logic [3:0]                           cnt_q, cnt_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic                                 write_q, write_d;
    logic                                 err_q, err_d;
    logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]                prdata_q, prdata_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;

    logic             pready;
    logic             in_err;
    logic [IDX_W-1:0] in_idx;

    // Out-of-range indices never touch storage, so the truncated index is safe.
    assign in_err = 32'(bus.PADDR_i) >= 32'(NUM_REGS);
    assign in_idx = bus.PADDR_i[IDX_W-1:0];
    assign pready = (state_q == ACCESS) && (cnt_q == 4'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        prdata_d = prdata_q;
        regs_d   = regs_q;
        case (state_q)
            IDLE: begin
                if (bus.PSEL_i && !bus.PENABLE_i) begin
                    idx_d   = in_idx;
                    write_d = bus.PWRITE_i;
                    wdata_d = bus.PWDATA_i;
                    err_d   = in_err;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (!bus.PWRITE_i)
                        prdata_d = in_err ? '0 : regs_q[in_idx];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.PSEL_i) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_q != 4'd0)
                        cnt_d = cnt_q - 4'd1;
                    if (bus.PENABLE_i && pready) begin
                        if (write_q && !err_q)
                            regs_d[idx_q] = wdata_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK_i) begin
        if (!PRESET_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            prdata_q <= '0;
            regs_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            prdata_q <= prdata_d;
            regs_q   <= regs_d;
        end
    end

    assign bus.PRDATA_o = prdata_q;
    assign bus.PREADY_o = pready;
`ifdef APB_SLV_ERR_EN
    assign bus.PSLVERR_o = pready & err_q;
`else
    assign bus.PSLVERR_o = 1'b0;
`endif
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: one zero-wait and one two-wait instance checked
// against an array model of register contents and APB transfer timing.
module tb_apb_slave_regfile;
    localparam int NREG = 32;

`ifdef APB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_slave_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if0 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) if1 ();

    apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_REGS(NREG), .WAIT_CYCLES(0))
        dut0 (.PCLK_i(clk), .PRESET_i(rst_n), .bus(if0));
    apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_REGS(NREG), .WAIT_CYCLES(2))
        dut1 (.PCLK_i(clk), .PRESET_i(rst_n), .bus(if1));

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [2][NREG];
    logic [7:0] last_rd [2];
    int         wait_of [2] = '{0, 2};

    function automatic logic [7:0] exp_read(input int d, input logic [7:0] a);
        return (a < NREG) ? mem[d][a] : 8'h00;
    endfunction

    function automatic bit exp_err(input logic [7:0] a);
        return ERR_EN && (a >= NREG);
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NREG; i++) mem[d][i] = 8'h00;
            last_rd[d] = 8'h00;
        end
    endtask

    task automatic drive(input int d, input bit sel, input bit en, input bit wr,
                         input logic [7:0] a, input logic [7:0] wd);
        if (d == 0) begin
            if0.PSEL_i = sel; if0.PENABLE_i = en; if0.PWRITE_i = wr;
            if0.PADDR_i = a;  if0.PWDATA_i = wd;
        end else begin
            if1.PSEL_i = sel; if1.PENABLE_i = en; if1.PWRITE_i = wr;
            if1.PADDR_i = a;  if1.PWDATA_i = wd;
        end
    endtask

    task automatic sample(input int d, output bit rdy, output bit se, output logic [7:0] rd);
        if (d == 0) begin rdy = if0.PREADY_o; se = if0.PSLVERR_o; rd = if0.PRDATA_o; end
        else        begin rdy = if1.PREADY_o; se = if1.PSLVERR_o; rd = if1.PRDATA_o; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        repeat (n) tick();
    endtask

    // One full transfer; returns observed data/error and total cycles (-1 on timeout).
    // Leaves the bus in the access phase so the next call follows with no bubble.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        input bit garble, output logic [7:0] rd, output bit serr,
                        output int cyc, output bit early_err);
        bit rdy, se;
        logic [7:0] r;
        rd = 8'h00; serr = 1'b0; early_err = 1'b0;
        drive(d, 1, 0, wr, a, wd);
        tick();
        drive(d, 1, 1, wr, a, wd);
        cyc = 1;
        for (int k = 0; k < 40; k++) begin
            cyc++;
            sample(d, rdy, se, r);
            if (rdy) begin
                rd = r; serr = se;
                tick();
                return;
            end
            if (se) early_err = 1'b1;
            if (garble) drive(d, 1, 1, wr, a ^ 8'h01, 8'h44);
            tick();
        end
        cyc = -1;
    endtask

    // Runs a transfer, updates the model and checks data, error, timing and PRDATA hold.
    task automatic check_xfer(input string tag, input int d, input bit wr,
                              input logic [7:0] a, input logic [7:0] wd, input bit garble);
        logic [7:0] rd, exp_rd;
        bit serr, early;
        int cyc;
        xfer(d, wr, a, wd, garble, rd, serr, cyc, early);
        exp_rd = wr ? last_rd[d] : exp_read(d, a);
        n_cmp++;
        if (cyc !== wait_of[d] + 2) begin
            n_bad++;
            $display("FAIL %s dut%0d cycles a=%02h: got %0d want %0d", tag, d, a, cyc, wait_of[d] + 2);
        end
        n_cmp++;
        if (rd !== exp_rd) begin
            n_bad++;
            $display("FAIL %s dut%0d prdata a=%02h wr=%0d: got %02h want %02h", tag, d, a, wr, rd, exp_rd);
        end
        n_cmp++;
        if (serr !== exp_err(a)) begin
            n_bad++;
            $display("FAIL %s dut%0d pslverr a=%02h: got %0d want %0d", tag, d, a, serr, exp_err(a));
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++;
            $display("FAIL %s dut%0d pslverr_without_pready: got 1 want 0", tag, d);
        end
        if (wr && a < NREG) mem[d][a] = wd;
        if (!wr) last_rd[d] = exp_rd;
    endtask

    task automatic test_reset();
        bit rdy, se;
        logic [7:0] r;
        rst_n = 1'b0;
        idle(3);
        for (int d = 0; d < 2; d++) begin
            sample(d, rdy, se, r);
            n_cmp++;
            if ({rdy, se, r} !== 10'd0) begin
                n_bad++;
                $display("FAIL reset_state dut%0d: got rdy=%0d err=%0d rd=%02h want all 0", d, rdy, se, r);
            end
        end
        rst_n = 1'b1;
        clear_model();
        check_xfer("reset_read", 0, 0, 8'h03, 8'h00, 0);
    endtask

    task automatic test_zero_wait();
        check_xfer("zw_write", 0, 1, 8'h15, 8'h28, 0);
        check_xfer("zw_read", 0, 0, 8'h15, 8'h00, 0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] da [3] = '{8'h72, 8'h66, 8'h09};
        for (int i = 0; i < 3; i++) check_xfer("b2b_write", 0, 1, 8'(i + 1), da[i], 0);
        for (int i = 0; i < 3; i++) check_xfer("b2b_read", 0, 0, 8'(i + 1), 8'h00, 0);
        idle(1);
    endtask

    task automatic test_wait_states();
        check_xfer("wait_write", 1, 1, 8'h04, 8'h87, 1);
        check_xfer("wait_read", 1, 0, 8'h04, 8'h00, 0);
        check_xfer("wait_read_nb", 1, 0, 8'h05, 8'h00, 0);
        idle(1);
    endtask

    task automatic test_error();
        for (int d = 0; d < 2; d++) begin
            check_xfer("err_write", d, 1, 8'h40, 8'h54, 0);
            check_xfer("err_read", d, 0, 8'h40, 8'h00, 0);
            check_xfer("err_alias", d, 0, 8'h00, 8'h00, 0);
            check_xfer("err_top", d, 1, 8'hFF, 8'hA5, 0);
            check_xfer("err_last", d, 0, 8'h1F, 8'h00, 0);
        end
        idle(1);
    endtask

    task automatic test_idle_penable();
        bit rdy, se;
        logic [7:0] r;
        drive(0, 1, 1, 1, 8'h15, 8'hEE);
        repeat (3) begin
            tick();
            sample(0, rdy, se, r);
            n_cmp++;
            if (rdy !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_penable pready: got %0d want 0", rdy);
            end
        end
        idle(1);
        check_xfer("idle_penable_read", 0, 0, 8'h15, 8'h00, 0);
        idle(1);
    endtask

    task automatic test_abort();
        bit rdy, se;
        logic [7:0] r;
        drive(1, 1, 0, 1, 8'h06, 8'h3C);
        tick();
        drive(1, 0, 1, 1, 8'h06, 8'h3C);
        tick();
        drive(1, 0, 0, 0, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) begin
            sample(1, rdy, se, r);
            n_cmp++;
            if (rdy !== 1'b0) begin
                n_bad++;
                $display("FAIL abort pready cycle %0d: got %0d want 0", k, rdy);
            end
            tick();
        end
        check_xfer("abort_read", 1, 0, 8'h06, 8'h00, 0);
        idle(1);
    endtask

    task automatic test_reset_mid();
        bit rdy, se;
        logic [7:0] r;
        check_xfer("rm_prewrite", 1, 1, 8'h05, 8'h5A, 0);
        drive(1, 1, 0, 1, 8'h05, 8'h99);
        tick();
        drive(1, 1, 1, 1, 8'h05, 8'h99);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            sample(1, rdy, se, r);
            n_cmp++;
            if (rdy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_mid pready cycle %0d: got %0d want 0", k, rdy);
            end
        end
        rst_n = 1'b1;
        clear_model();
        idle(1);
        check_xfer("reset_mid_read", 1, 0, 8'h05, 8'h00, 0);
        check_xfer("reset_mid_read0", 0, 0, 8'h15, 8'h00, 0);
        idle(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            int d;
            bit wr;
            logic [7:0] a, wd;
            d  = i % 2;
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
            wd = 8'($urandom);
            check_xfer("random", d, wr, a, wd, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
    endtask

    initial begin
        clear_model();
        idle(1);
        test_reset();
        test_zero_wait();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_idle_penable();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
